// File: rtl/maxpool_relu_wb_if.sv
// Write-back stage bus: pixel stream in from the convolve engine, pooled pixels out.
// The master drives frame control and pixels; the slave (the pooling stage) drives results.
interface maxpool_relu_wb_if #(
  parameter int BIT_DEPTH = 8,
  parameter int COL_AW    = 5,
  parameter int OUT_AW    = 6
);
  logic                 start;
  logic                 in_valid;
  logic [COL_AW-1:0]    in_col;
  logic [BIT_DEPTH-1:0] in_data;
  logic                 out_valid;
  logic [OUT_AW-1:0]    out_addr;
  logic [BIT_DEPTH-1:0] out_data;
  logic                 busy;
  logic                 frame_done;
  logic                 col_err;

  modport master (
    output start, in_valid, in_col, in_data,
    input  out_valid, out_addr, out_data, busy, frame_done, col_err
  );

  modport slave (
    input  start, in_valid, in_col, in_data,
    output out_valid, out_addr, out_data, busy, frame_done, col_err
  );
endinterface

// File: rtl/maxpool_relu_wb.sv
// Optional ReLU then 2x2/stride-2 max pool over a raster pixel stream, linear write-back.
// Define MAXPOOL_RELU_EN to clamp negative (two's complement) inputs to zero before pooling.
module maxpool_relu_wb #(
  parameter int BIT_DEPTH = 8,
  parameter int FMAP_W    = 14,
  parameter int FMAP_H    = 14,
  parameter int COL_AW    = 5,
  parameter int OUT_AW    = 6
) (
  input logic              clk,
  input logic              rst,
  maxpool_relu_wb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EVEN_ROW, ODD_ROW, DONE} state_t;

  localparam int HW       = FMAP_W / 2;
  localparam int BW       = (HW > 1) ? $clog2(HW) : 1;
  localparam int RW       = $clog2(FMAP_H + 1);
  localparam int LAST_ROW = 2 * (FMAP_H / 2) - 1;

  state_t               state;
  logic [COL_AW-1:0]    col;
  logic [RW-1:0]        row;
  logic [BIT_DEPTH-1:0] hold;
  logic [BIT_DEPTH-1:0] rowbuf [HW];

  logic                 out_valid_q, frame_done_q, col_err_q;
  logic [OUT_AW-1:0]    out_addr_q;
  logic [BIT_DEPTH-1:0] out_data_q;

  logic [BIT_DEPTH-1:0] px, pmax, above, pool;
  logic [BW-1:0]        bidx;
  logic [OUT_AW-1:0]    addr_nxt;
  logic                 active, last_col;

`ifdef MAXPOOL_RELU_EN
  assign px = bus.in_data[BIT_DEPTH-1] ? '0 : bus.in_data;
`else
  assign px = bus.in_data;
`endif

  assign active   = (state == EVEN_ROW) || (state == ODD_ROW);
  assign last_col = (col == COL_AW'(FMAP_W - 1));
  assign bidx     = BW'(col >> 1);
  assign above    = rowbuf[bidx];
  assign pmax     = (px > hold) ? px : hold;
  assign pool     = (pmax > above) ? pmax : above;
  assign addr_nxt = OUT_AW'(int'(row >> 1) * HW + int'(col >> 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      hold         <= '0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
      col_err_q    <= 1'b0;
    end else begin
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (bus.start) begin
        // A pixel arriving with start is dropped; the new frame begins next cycle.
        state     <= EVEN_ROW;
        col       <= '0;
        row       <= '0;
        col_err_q <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          DONE: begin
            state        <= IDLE;
            frame_done_q <= 1'b1;
          end
          default: if (bus.in_valid) begin
            if (bus.in_col != col) col_err_q <= 1'b1;
            // An unpaired last column of odd-width maps only lands in hold and is never used.
            if (!col[0]) begin
              hold <= px;
            end else if (state == ODD_ROW) begin
              out_valid_q <= 1'b1;
              out_data_q  <= pool;
              out_addr_q  <= addr_nxt;
            end
            if (last_col) begin
              col <= '0;
              row <= row + 1'b1;
              if (state == EVEN_ROW)           state <= ODD_ROW;
              else if (row == RW'(LAST_ROW))   state <= DONE;
              else                             state <= EVEN_ROW;
            end else begin
              col <= col + 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Row buffer holds horizontal maxima of the even row; contents need no reset.
  always_ff @(posedge clk) begin
    if (!rst && !bus.start && state == EVEN_ROW && bus.in_valid && col[0])
      rowbuf[bidx] <= pmax;
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_addr   = out_addr_q;
  assign bus.out_data   = out_data_q;
  assign bus.busy       = active;
  assign bus.frame_done = frame_done_q;
  assign bus.col_err    = col_err_q;
endmodule

// File: tb/tb_maxpool_relu_wb.sv
// Directed bench: pixel-stream model for a 4x4 instance checked every cycle, plus literal
// expectations for each scenario and a 5x5 instance for odd-dimension discards.
module tb_maxpool_relu_wb;
  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  maxpool_relu_wb_if #(.BIT_DEPTH(8), .COL_AW(5), .OUT_AW(6)) ia ();
  maxpool_relu_wb_if #(.BIT_DEPTH(8), .COL_AW(5), .OUT_AW(6)) ib ();

  maxpool_relu_wb #(.BIT_DEPTH(8), .FMAP_W(W), .FMAP_H(H), .COL_AW(5), .OUT_AW(6))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  maxpool_relu_wb #(.BIT_DEPTH(8), .FMAP_W(5), .FMAP_H(5), .COL_AW(5), .OUT_AW(6))
    dut_b (.clk(clk), .rst(rst), .bus(ib));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] relu(input logic [7:0] d);
`ifdef MAXPOOL_RELU_EN
    return d[7] ? 8'd0 : d;
`else
    return d;
`endif
  endfunction

  function automatic logic [7:0] max2(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  // ---------------- model: fills an image, emits a window max when it completes ----------
  int cyc = 0;
  bit act_m = 0, fd_pend = 0;
  int n = 0;
  logic [7:0] img [H][W];
  logic e_ov = 0, e_fd = 0, e_err = 0, e_busy = 0;
  int e_addr = 0;
  logic [7:0] e_data = 0;

  always @(posedge clk) begin
    int r, c;
    cyc++;
    if (rst) begin
      act_m = 0; n = 0; fd_pend = 0; e_ov = 0; e_fd = 0; e_err = 0;
    end else begin
      e_ov = 0;
      e_fd = fd_pend;
      fd_pend = 0;
      if (ia.start) begin
        act_m = 1; n = 0; e_err = 0;
      end else if (act_m && ia.in_valid) begin
        r = n / W; c = n % W;
        img[r][c] = relu(ia.in_data);
        if (int'(ia.in_col) != c) e_err = 1;
        n++;
        if (r % 2 == 1 && c % 2 == 1) begin
          e_ov   = 1;
          e_addr = (r / 2) * (W / 2) + c / 2;
          e_data = max2(max2(img[r-1][c-1], img[r-1][c]), max2(img[r][c-1], img[r][c]));
        end
        if (n == 2 * (H / 2) * W) begin
          act_m = 0; fd_pend = 1;
        end
      end
    end
    e_busy = act_m;
  end

  // ---------------- compare + output logging ----------------
  int la_addr[$], la_data[$], lb_addr[$], lb_data[$];
  int fd_a = 0, fd_b = 0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("out_valid", ia.out_valid, e_ov);
      if (e_ov) begin
        chk("out_addr", ia.out_addr, e_addr);
        chk("out_data", ia.out_data, e_data);
      end
      chk("frame_done", ia.frame_done, e_fd);
      chk("busy", ia.busy, e_busy);
      chk("col_err", ia.col_err, e_err);
      if (ia.out_valid === 1'b1) begin la_addr.push_back(ia.out_addr); la_data.push_back(ia.out_data); end
      if (ia.frame_done === 1'b1) fd_a++;
      if (ib.out_valid === 1'b1) begin lb_addr.push_back(ib.out_addr); lb_data.push_back(ib.out_data); end
      if (ib.frame_done === 1'b1) fd_b++;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] frm [16];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    repeat (k) step();
  endtask

  task automatic px_a(input logic [7:0] d, input int c);
    ia.in_valid = 1; ia.in_data = d; ia.in_col = 5'(c);
    step();
    ia.in_valid = 0;
  endtask

  task automatic start_a();
    ia.start = 1; step(); ia.start = 0;
    la_addr.delete(); la_data.delete(); fd_a = 0;
  endtask

  task automatic send_a(input int gap, input int bad);
    for (int i = 0; i < 16; i++) begin
      px_a(frm[i], (i == bad) ? (i % W) + 1 : i % W);
      idle(gap);
    end
    idle(4);
  endtask

  task automatic chk_out4(input string tag, input int d0, input int d1, input int d2, input int d3);
    int ed[4];
    ed = '{d0, d1, d2, d3};
    chk({tag, "_count"}, la_addr.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < la_addr.size()) begin
        chk({tag, "_addr"}, la_addr[i], i);
        chk({tag, "_data"}, la_data[i], ed[i]);
      end
  endtask

  initial begin
    ia.start = 0; ia.in_valid = 0; ia.in_col = 0; ia.in_data = 0;
    ib.start = 0; ib.in_valid = 0; ib.in_col = 0; ib.in_data = 0;
    idle(2);
    rst = 0;
    chk("rst_out_valid", ia.out_valid, 0);
    chk("rst_busy", ia.busy, 0);
    chk("rst_col_err", ia.col_err, 0);
    chk("rst_frame_done", ia.frame_done, 0);
    chk("rst_out_data", ia.out_data, 0);

    // 1: ramp frame
    for (int i = 0; i < 16; i++) frm[i] = 8'(i + 1);
    start_a(); send_a(0, -1);
    chk_out4("c1", 6, 8, 14, 16);
    chk("c1_fd", fd_a, 1);
    chk("c1_col_err", ia.col_err, 0);

    // 2: max location varies within window
    frm = '{8'd9, 8'd2, 8'd3, 8'd1, 8'd0, 8'd0, 8'd0, 8'd7,
            8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    start_a(); send_a(0, -1);
    chk_out4("c2", 9, 7, 0, 0);

    // 3: negative-looking data
    for (int i = 0; i < 16; i++) frm[i] = 8'hF0;
    start_a(); send_a(0, -1);
`ifdef MAXPOOL_RELU_EN
    chk_out4("c3", 0, 0, 0, 0);
`else
    chk_out4("c3", 8'hF0, 8'hF0, 8'hF0, 8'hF0);
`endif

    // 4: idle gaps
    for (int i = 0; i < 16; i++) frm[i] = 8'(i + 1);
    start_a(); send_a(3, -1);
    chk_out4("c4", 6, 8, 14, 16);
    chk("c4_fd", fd_a, 1);

    // 5: wrong column on 3rd pixel
    start_a(); send_a(0, 2);
    chk_out4("c5", 6, 8, 14, 16);
    chk("c5_col_err_set", ia.col_err, 1);
    start_a();
    chk("c5_col_err_clr", ia.col_err, 0);

    // 6: restart mid-frame, then rst mid-row
    for (int i = 0; i < 6; i++) px_a(frm[i], i % W);
    start_a(); send_a(0, -1);
    chk_out4("c6", 6, 8, 14, 16);
    chk("c6_fd", fd_a, 1);
    start_a();
    px_a(8'd1, 0); px_a(8'd2, 1);
    rst = 1; step(); rst = 0;
    chk("c6_rst_busy", ia.busy, 0);
    idle(4);
    chk("c6_rst_fd", fd_a, 0);

    // 7: 5x5 instance, column 4 and row 4 discarded
    ib.start = 1; step(); ib.start = 0;
    for (int i = 0; i < 25; i++) begin
      ib.in_valid = 1; ib.in_data = 8'(i + 1); ib.in_col = 5'(i % 5);
      step();
    end
    ib.in_valid = 0;
    idle(4);
    chk("c7_count", lb_addr.size(), 4);
    if (lb_addr.size() == 4) begin
      chk("c7_d0", lb_data[0], 7);  chk("c7_a3", lb_addr[3], 3);
      chk("c7_d1", lb_data[1], 9);  chk("c7_d2", lb_data[2], 17);
      chk("c7_d3", lb_data[3], 19);
    end
    chk("c7_fd", fd_b, 1);
    chk("c7_busy", ib.busy, 0);
    chk("c7_col_err", ib.col_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
